// File: rtl/idu_pkg.sv
// Shared types, widths and helpers for the N-lane instruction decode stage.
package idu_pkg;

    localparam int unsigned IDU_MAX_LANES   = 4;
    localparam int unsigned INST_DATA_WIDTH = 32;
    localparam int unsigned INST_ADDR_WIDTH = 32;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_FENCE  = 7'b0001111,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic                       valid;
        logic [INST_DATA_WIDTH-1:0] inst;
        logic [INST_ADDR_WIDTH-1:0] addr;
        logic                       reg_we;
        logic [4:0]                 reg_waddr;
        logic [4:0]                 reg1_raddr;
        logic [4:0]                 reg2_raddr;
        logic                       csr_we;
        logic [11:0]                csr_waddr;
        logic [11:0]                csr_raddr;
        logic [31:0]                imm;
        logic [9:0]                 dec_info;   // {funct3, opcode}
        logic                       pred_branch;
        logic                       illegal;
        logic                       jump;
        logic                       branch;
        logic                       csr_type;
    } idu_lane_t;

    // Lowest contiguous run of ones starting at bit 0.
    function automatic logic [IDU_MAX_LANES-1:0] prefix_mask(input logic [IDU_MAX_LANES-1:0] mask);
        logic run;
        prefix_mask = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < IDU_MAX_LANES; i++) begin
            run = run & mask[i];
            prefix_mask[i] = run;
        end
    endfunction

endpackage

// File: rtl/idu_bundle_fifo.sv
// Bundle FIFO: storage, pointers, count, per-lane done mask and head retire.
module idu_bundle_fifo
    import idu_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 2,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned SERIALIZE_CSR = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic                            wr_en_i,
    input  idu_lane_t [NUM_LANES-1:0]       wr_lanes_i,
    input  logic [NUM_LANES-1:0]            ack_i,
    output logic                            full_o,
    output logic                            empty_o,
    output logic                            partial_o,
    output logic [NUM_LANES-1:0]            head_valid_o,
    output idu_lane_t [NUM_LANES-1:0]       head_lanes_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    idu_lane_t [NUM_LANES-1:0] mem_q [DEPTH];
    idu_lane_t [NUM_LANES-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [NUM_LANES-1:0]      done_q, done_d;
    logic [NUM_LANES-1:0]      stored_vld, pend, ack_eff;
    logic                      ser_block, retire;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);

    always_comb begin
        head_lanes_o = '0;
        stored_vld   = '0;
        head_valid_o = '0;
        ser_block    = 1'b0;
        if (!empty_o) begin
            head_lanes_o = mem_q[rd_ptr_q];
            for (int unsigned i = 0; i < NUM_LANES; i++) stored_vld[i] = mem_q[rd_ptr_q][i].valid;
        end
        pend = stored_vld & ~done_q;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            head_valid_o[i] = pend[i] & ~ser_block;
            if (SERIALIZE_CSR != 0 && pend[i] && (head_lanes_o[i].csr_type || head_lanes_o[i].illegal))
                ser_block = 1'b1;
        end
        // Done lanes are always an in-order prefix, so OR-ing them in lets one
        // prefix scan find the contiguous ack run starting at the oldest pending lane.
        ack_eff   = NUM_LANES'(prefix_mask(IDU_MAX_LANES'((ack_i & head_valid_o) | done_q))) & ~done_q;
        retire    = !empty_o && (((done_q | ack_eff) & stored_vld) == stored_vld);
        partial_o = (ack_eff != '0) && !retire;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        done_d   = done_q | ack_eff;
        count_d  = count_q + CNT_W'(wr_en_i) - CNT_W'(retire);
        if (wr_en_i) begin
            mem_d[wr_ptr_q] = wr_lanes_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (retire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            done_d   = '0;
        end
        if (flush_i) begin
            mem_d    = mem_q;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            done_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: rtl/idu_decode.sv
// Single-lane combinational RV32I decoder; all fields are zero when the lane is invalid.
module idu_decode
    import idu_pkg::*;
(
    input  logic                       valid_i,
    input  logic [INST_DATA_WIDTH-1:0] inst_i,
    input  logic [INST_ADDR_WIDTH-1:0] addr_i,
    input  logic                       pred_branch_i,
    output idu_lane_t                  lane_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm_i;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign rd     = inst_i[11:7];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};

    always_comb begin
        lane_o = '0;
        if (valid_i) begin
            lane_o.valid       = 1'b1;
            lane_o.inst        = inst_i;
            lane_o.addr        = addr_i;
            lane_o.pred_branch = pred_branch_i;
            lane_o.dec_info    = {funct3, opcode};
            case (opcode)
                OPC_LUI, OPC_AUIPC: begin
                    lane_o.reg_we = 1'b1; lane_o.reg_waddr = rd;
                    lane_o.imm = {inst_i[31:12], 12'b0};
                end
                OPC_JAL: begin
                    lane_o.reg_we = 1'b1; lane_o.reg_waddr = rd; lane_o.jump = 1'b1;
                    lane_o.imm = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
                end
                OPC_JALR: begin
                    lane_o.reg_we = 1'b1; lane_o.reg_waddr = rd; lane_o.reg1_raddr = rs1;
                    lane_o.jump = 1'b1; lane_o.imm = imm_i;
                end
                OPC_BRANCH: begin
                    lane_o.reg1_raddr = rs1; lane_o.reg2_raddr = rs2; lane_o.branch = 1'b1;
                    lane_o.imm = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
                end
                OPC_LOAD, OPC_OP_IMM: begin
                    lane_o.reg_we = 1'b1; lane_o.reg_waddr = rd; lane_o.reg1_raddr = rs1;
                    lane_o.imm = imm_i;
                end
                OPC_STORE: begin
                    lane_o.reg1_raddr = rs1; lane_o.reg2_raddr = rs2;
                    lane_o.imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
                end
                OPC_OP: begin
                    lane_o.reg_we = 1'b1; lane_o.reg_waddr = rd;
                    lane_o.reg1_raddr = rs1; lane_o.reg2_raddr = rs2;
                end
                OPC_FENCE: ;
                OPC_SYSTEM: begin
                    // ECALL/EBREAK also serialize, so the whole opcode is CSR-type.
                    lane_o.csr_type = 1'b1;
                    if (funct3 != 3'b000) begin
                        lane_o.reg_we = 1'b1; lane_o.reg_waddr = rd;
                        lane_o.csr_we = 1'b1;
                        lane_o.csr_waddr = inst_i[31:20]; lane_o.csr_raddr = inst_i[31:20];
                        if (funct3[2]) lane_o.imm = {27'b0, rs1};
                        else           lane_o.reg1_raddr = rs1;
                    end
                end
                default: lane_o.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/idu_nway.sv
// N-lane decode stage: per-lane decoders feeding a bundle FIFO with partial-issue ack.
// Optional perf counters are built when IDU_PERF_CNT_EN is defined.
module idu_nway
    import idu_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 2,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned SERIALIZE_CSR = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [NUM_LANES-1:0]                 in_lane_valid_i,
    input  logic [NUM_LANES*INST_DATA_WIDTH-1:0] in_inst_i,
    input  logic [NUM_LANES*INST_ADDR_WIDTH-1:0] in_addr_i,
    input  logic [NUM_LANES-1:0]                 in_pred_branch_i,
    input  logic                                 flush_i,
    output logic [NUM_LANES-1:0]                 out_lane_valid_o,
    output logic [NUM_LANES*$bits(idu_lane_t)-1:0] out_lane_o,
    input  logic [NUM_LANES-1:0]                 issue_ack_i,
    output logic                                 empty_o
`ifdef IDU_PERF_CNT_EN
    ,
    output logic [31:0]                          perf_stall_cnt_o,
    output logic [31:0]                          perf_partial_cnt_o
`endif
);

    logic [NUM_LANES-1:0]      eff_mask;
    idu_lane_t [NUM_LANES-1:0] dec_lanes, head_lanes;
    logic                      fifo_full, wr_en, ack_partial;

    assign eff_mask   = NUM_LANES'(prefix_mask(IDU_MAX_LANES'(in_lane_valid_i)));
    assign in_ready_o = rst_n & ~fifo_full;
    assign wr_en      = in_valid_i & in_ready_o & (eff_mask != '0) & ~flush_i;
    assign out_lane_o = head_lanes;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        idu_decode u_decode (
            .valid_i       (eff_mask[g]),
            .inst_i        (in_inst_i[g*INST_DATA_WIDTH +: INST_DATA_WIDTH]),
            .addr_i        (in_addr_i[g*INST_ADDR_WIDTH +: INST_ADDR_WIDTH]),
            .pred_branch_i (in_pred_branch_i[g]),
            .lane_o        (dec_lanes[g])
        );
    end

    idu_bundle_fifo #(
        .NUM_LANES     (NUM_LANES),
        .DEPTH         (DEPTH),
        .SERIALIZE_CSR (SERIALIZE_CSR)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .wr_en_i      (wr_en),
        .wr_lanes_i   (dec_lanes),
        .ack_i        (issue_ack_i),
        .full_o       (fifo_full),
        .empty_o      (empty_o),
        .partial_o    (ack_partial),
        .head_valid_o (out_lane_valid_o),
        .head_lanes_o (head_lanes)
    );

`ifdef IDU_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, partial_cnt_q, partial_cnt_d;

    always_comb begin
        stall_cnt_d   = stall_cnt_q + 32'(in_valid_i & ~in_ready_o);
        partial_cnt_d = partial_cnt_q + 32'(ack_partial);
        if (flush_i) begin
            stall_cnt_d   = '0;
            partial_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            partial_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            partial_cnt_q <= partial_cnt_d;
        end
    end

    assign perf_stall_cnt_o   = stall_cnt_q;
    assign perf_partial_cnt_o = partial_cnt_q;
`else
    logic unused_ack_partial;
    assign unused_ack_partial = ack_partial;
`endif

endmodule

// File: tb/tb_idu_nway.sv
// Table-driven bench for idu_nway (NUM_LANES=2, DEPTH=2, SERIALIZE_CSR=1).
module tb_idu_nway;
    import idu_pkg::*;

    localparam int unsigned NL = 2;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093; // addi x1, x0, 5
    localparam logic [31:0] I_ADD   = 32'h0020_81B3; // add  x3, x1, x2
    localparam logic [31:0] I_CSRRW = 32'h3000_92F3; // csrrw x5, 0x300, x1

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                              rst_n, in_valid, in_ready, flush, empty;
    logic [NL-1:0]                     lane_valid, pred_branch, olv, ack;
    logic [NL*32-1:0]                  inst, addr;
    logic [NL*$bits(idu_lane_t)-1:0]   out_lane;
    idu_lane_t [NL-1:0]                head;
`ifdef IDU_PERF_CNT_EN
    logic [31:0] perf_stall, perf_partial;
`endif

    assign head = out_lane;

    idu_nway #(
        .NUM_LANES     (NL),
        .DEPTH         (2),
        .SERIALIZE_CSR (1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_lane_valid_i  (lane_valid),
        .in_inst_i        (inst),
        .in_addr_i        (addr),
        .in_pred_branch_i (pred_branch),
        .flush_i          (flush),
        .out_lane_valid_o (olv),
        .out_lane_o       (out_lane),
        .issue_ack_i      (ack),
        .empty_o          (empty)
`ifdef IDU_PERF_CNT_EN
        ,
        .perf_stall_cnt_o   (perf_stall),
        .perf_partial_cnt_o (perf_partial)
`endif
    );

    typedef struct {
        logic        iv;
        logic [1:0]  lv;
        logic [31:0] i0, i1, a0, a1;
        logic [1:0]  ack;
        logic        fl;
        logic        e_rdy;
        logic [1:0]  e_olv;
        logic        e_emp;
        logic [31:0] e_h0, e_h1;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] k, input logic fl,
                       input logic e_rdy, input logic [1:0] e_olv, input logic e_emp,
                       input logic [31:0] e_h0, input logic [31:0] e_h1);
        vec_t v;
        v.iv = iv; v.lv = lv; v.i0 = i0; v.i1 = i1; v.a0 = a0; v.a1 = a1; v.ack = k; v.fl = fl;
        v.e_rdy = e_rdy; v.e_olv = e_olv; v.e_emp = e_emp; v.e_h0 = e_h0; v.e_h1 = e_h1;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic [1:0] k, input logic e_rdy, input logic [1:0] e_olv,
                        input logic e_emp, input logic [31:0] e_h0, input logic [31:0] e_h1);
        add(1'b0, 2'b00, '0, '0, '0, '0, k, 1'b0, e_rdy, e_olv, e_emp, e_h0, e_h1);
    endtask

    task automatic drive(input logic iv, input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] k, input logic fl);
        in_valid = iv; lane_valid = lv; inst = {i1, i0}; addr = {a1, a0}; ack = k; flush = fl;
    endtask

    initial begin
        rst_n = 1'b0; pred_branch = '0;
        drive(1'b1, 2'b11, I_ADDI, I_ADD, 32'h100, 32'h104, 2'b00, 1'b0);

        // Reset state, sampled while rst_n is still low
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_ready", {31'b0, in_ready}, 32'd0);
        check("reset_olv",   {30'b0, olv},      32'd0);
        check("reset_empty", {31'b0, empty},    32'd1);
        check("reset_lanes", {31'b0, |out_lane}, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b00, 1'b0);

        // Basic accept, latency, full ack
        add(1, 2'b11, I_ADDI, I_ADD, 32'h100, 32'h104, 2'b00, 0,  1, 2'b00, 1, 0, 0);
        idle(2'b00, 1, 2'b11, 0, 32'h100, 32'h104);
        idle(2'b11, 1, 2'b11, 0, 32'h100, 32'h104);
        idle(2'b00, 1, 2'b00, 1, 0, 0);
        // Partial issue, out-of-order ack ignored
        add(1, 2'b11, I_ADDI, I_ADD, 32'h100, 32'h104, 2'b00, 0,  1, 2'b00, 1, 0, 0);
        idle(2'b10, 1, 2'b11, 0, 32'h100, 32'h104);
        idle(2'b01, 1, 2'b11, 0, 32'h100, 32'h104);
        idle(2'b00, 1, 2'b10, 0, 32'h100, 32'h104);
        idle(2'b10, 1, 2'b10, 0, 32'h100, 32'h104);
        idle(2'b00, 1, 2'b00, 1, 0, 0);
        // Fill, backpressure, ack while full, pointer wrap
        add(1, 2'b11, I_ADDI, I_ADD, 32'h100, 32'h104, 2'b00, 0,  1, 2'b00, 1, 0, 0);
        add(1, 2'b11, I_ADD, I_ADDI, 32'h200, 32'h204, 2'b00, 0,  1, 2'b11, 0, 32'h100, 32'h104);
        add(1, 2'b11, I_ADDI, I_ADD, 32'h300, 32'h304, 2'b00, 0,  0, 2'b11, 0, 32'h100, 32'h104);
        add(1, 2'b11, I_ADDI, I_ADD, 32'h300, 32'h304, 2'b11, 0,  0, 2'b11, 0, 32'h100, 32'h104);
        add(1, 2'b11, I_ADDI, I_ADD, 32'h300, 32'h304, 2'b00, 0,  1, 2'b11, 0, 32'h200, 32'h204);
        idle(2'b11, 0, 2'b11, 0, 32'h200, 32'h204);
        idle(2'b11, 1, 2'b11, 0, 32'h300, 32'h304);
        idle(2'b00, 1, 2'b00, 1, 0, 0);
        // CSR serialization
        add(1, 2'b11, I_CSRRW, I_ADD, 32'h400, 32'h404, 2'b00, 0,  1, 2'b00, 1, 0, 0);
        idle(2'b00, 1, 2'b01, 0, 32'h400, 32'h404);
        idle(2'b11, 1, 2'b01, 0, 32'h400, 32'h404);
        idle(2'b00, 1, 2'b10, 0, 32'h400, 32'h404);
        idle(2'b10, 1, 2'b10, 0, 32'h400, 32'h404);
        idle(2'b00, 1, 2'b00, 1, 0, 0);
        // Flush with two stored (ack discarded), then flush against a same-cycle accept
        add(1, 2'b11, I_ADDI, I_ADD, 32'h100, 32'h104, 2'b00, 0,  1, 2'b00, 1, 0, 0);
        add(1, 2'b11, I_ADD, I_ADDI, 32'h200, 32'h204, 2'b00, 0,  1, 2'b11, 0, 32'h100, 32'h104);
        add(1, 2'b11, I_ADDI, I_ADD, 32'h300, 32'h304, 2'b11, 1,  0, 2'b11, 0, 32'h100, 32'h104);
        idle(2'b00, 1, 2'b00, 1, 0, 0);
        add(1, 2'b11, I_ADDI, I_ADD, 32'h100, 32'h104, 2'b00, 0,  1, 2'b00, 1, 0, 0);
        add(1, 2'b11, I_ADDI, I_ADD, 32'h300, 32'h304, 2'b00, 1,  1, 2'b11, 0, 32'h100, 32'h104);
        idle(2'b00, 1, 2'b00, 1, 0, 0);
        idle(2'b00, 1, 2'b00, 1, 0, 0);
        // Non-prefix mask dropped; single-lane bundle with zero-filled lane 1
        add(1, 2'b10, I_ADD, I_ADDI, 32'h200, 32'h204, 2'b00, 0,  1, 2'b00, 1, 0, 0);
        idle(2'b00, 1, 2'b00, 1, 0, 0);
        add(1, 2'b01, I_ADDI, I_ADD, 32'h100, 32'h104, 2'b00, 0,  1, 2'b00, 1, 0, 0);
        idle(2'b00, 1, 2'b01, 0, 32'h100, 32'h0);
        idle(2'b01, 1, 2'b01, 0, 32'h100, 32'h0);
        idle(2'b00, 1, 2'b00, 1, 0, 0);

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].iv, vecs[k].lv, vecs[k].i0, vecs[k].i1, vecs[k].a0, vecs[k].a1, vecs[k].ack, vecs[k].fl);
            #1;
            check($sformatf("v%0d_ready", k), {31'b0, in_ready}, {31'b0, vecs[k].e_rdy});
            check($sformatf("v%0d_olv", k),   {30'b0, olv},      {30'b0, vecs[k].e_olv});
            check($sformatf("v%0d_empty", k), {31'b0, empty},    {31'b0, vecs[k].e_emp});
            check($sformatf("v%0d_addr0", k), head[0].addr,      vecs[k].e_h0);
            check($sformatf("v%0d_addr1", k), head[1].addr,      vecs[k].e_h1);
        end

        // Decoded field spot-check on a CSR + ADD bundle
        @(negedge clk);
        drive(1'b1, 2'b11, I_CSRRW, I_ADD, 32'h500, 32'h504, 2'b00, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b00, 1'b0);
        #1;
        check("dec_csr_type", {31'b0, head[0].csr_type}, 32'd1);
        check("dec_csr_addr", {20'b0, head[0].csr_waddr}, 32'h300);
        check("dec_csr_rd",   {27'b0, head[0].reg_waddr}, 32'd5);
        check("dec_add_rs",   {22'b0, head[1].reg1_raddr, head[1].reg2_raddr}, {22'b0, 5'd1, 5'd2});
        check("dec_add_inst", head[1].inst, I_ADD);
        @(negedge clk);
        drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b00, 1'b1);
        @(negedge clk);
        drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b00, 1'b0);
        #1;
        check("flush_clear", {31'b0, empty}, 32'd1);

`ifdef IDU_PERF_CNT_EN
        check("perf_clear", perf_stall, 32'd0);
        @(negedge clk); drive(1'b1, 2'b11, I_ADDI, I_ADD, 32'h100, 32'h104, 2'b00, 1'b0);
        @(negedge clk); drive(1'b1, 2'b11, I_ADD, I_ADDI, 32'h200, 32'h204, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(1'b1, 2'b11, I_ADDI, I_ADD, 32'h300, 32'h304, 2'b00, 1'b0);
        end
        @(negedge clk); drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b01, 1'b0);
        #1;
        check("perf_stall5", perf_stall, 32'd5);
        @(negedge clk); drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b10, 1'b0);
        @(negedge clk); drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b11, 1'b0);
        @(negedge clk); drive(1'b0, 2'b00, '0, '0, '0, '0, 2'b00, 1'b0);
        #1;
        check("perf_partial", perf_partial, 32'd1);
        check("perf_drained", {31'b0, empty}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
